keypad_matrix_responder: RTL

- Emulates the mechanical side of the 4x4 keypad matrix: the column-driving scanner (key_pad_cntr / keypad_cntr_FSM) drives col, and this block drives row back.
- Accepts "press key N for H cycles" commands over a valid/ready handshake. It then plays out a press with contact bounce, a stable hold, and a release with contact bounce.
- Used as an in-fabric key injector for SoC bring-up (processor-driven key presses) and as the keypad model in scanner testbenches.

---
 rtl/keypad_matrix_responder.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/keypad_matrix_responder.sv
// keypad_matrix_responder: drives the row lines of a 4x4 keypad matrix in
// response to the scanner's column drive. It plays back commanded key presses
// as press bounce, a stable hold, release bounce, and then a done pulse.
module keypad_matrix_responder #(
  parameter int unsigned BOUNCE_PERIOD  = 8,
  parameter int unsigned BOUNCE_TOGGLES = 4,
  parameter int unsigned HOLD_W         = 16
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic [3:0]        col,
  output logic [3:0]        row,
  input  logic              press_valid,
  output logic              press_ready,
  input  logic [3:0]        press_key,
  input  logic [HOLD_W-1:0] press_hold,
  input  logic              abort,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PH_W    = (BOUNCE_PERIOD  > 1) ? $clog2(BOUNCE_PERIOD)  : 1;
  localparam int unsigned TG_W    = (BOUNCE_TOGGLES > 1) ? $clog2(BOUNCE_TOGGLES) : 1;
  localparam int unsigned PH_LAST = (BOUNCE_PERIOD  > 0) ? BOUNCE_PERIOD  - 1 : 0;
  localparam int unsigned TG_LAST = (BOUNCE_TOGGLES > 0) ? BOUNCE_TOGGLES - 1 : 0;
  localparam bit          HAS_BNC = (BOUNCE_TOGGLES != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS_BNC,
    S_HELD,
    S_REL_BNC,
    S_DONE
  } state_t;

  state_t            r_state;
  logic              r_contact;
  logic              r_done;
  logic [3:0]        r_key;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [PH_W-1:0]   r_phase;
  logic [TG_W-1:0]   r_tog;

  logic [HOLD_W-1:0] w_hold_eff;
  logic              w_accept;
  logic              w_phase_end;
  logic              w_tog_end;
  logic              w_col_hit;
  logic [3:0]        w_row_bit;

  // Command acceptance and bounce-phase end detection.
  assign w_hold_eff  = (press_hold == '0) ? HOLD_W'(1) : press_hold;
  assign press_ready = (r_state == S_IDLE) && !abort;
  assign w_accept    = press_valid && press_ready;
  assign w_phase_end = (r_phase == PH_W'(PH_LAST));
  assign w_tog_end   = (r_tog == TG_W'(TG_LAST));

  // Row return follows the live column drive with zero latency.
  assign w_col_hit = col[r_key[1:0]];
  assign w_row_bit = 4'b0001 << r_key[3:2];
  assign row       = (r_contact && w_col_hit) ? w_row_bit : 4'b0000;

  assign busy = (r_state != S_IDLE);
  assign done = r_done;

  // Press/hold/release sequencer; contact is registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_state    <= S_IDLE;
      r_contact  <= 1'b0;
      r_done     <= 1'b0;
      r_key      <= '0;
      r_hold     <= '0;
      r_hold_cnt <= '0;
      r_phase    <= '0;
      r_tog      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_contact <= 1'b0;
          if (w_accept) begin
            r_key     <= press_key;
            r_hold    <= w_hold_eff;
            r_phase   <= '0;
            r_tog     <= '0;
            r_contact <= 1'b1;
            if (HAS_BNC) begin
              r_state <= S_PRESS_BNC;
            end else begin
              r_state    <= S_HELD;
              r_hold_cnt <= w_hold_eff;
            end
          end
        end

        S_PRESS_BNC: begin
          if (abort) begin
            r_state   <= S_IDLE;
            r_contact <= 1'b0;
          end else if (w_phase_end) begin
            r_phase <= '0;
            if (w_tog_end) begin
              r_state    <= S_HELD;
              r_hold_cnt <= r_hold;
              r_tog      <= '0;
              r_contact  <= 1'b1;
            end else begin
              // Next phase index is r_tog+1: closed when it is even.
              r_tog     <= r_tog + TG_W'(1);
              r_contact <= r_tog[0];
            end
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end

        S_HELD: begin
          if (abort) begin
            r_state   <= S_IDLE;
            r_contact <= 1'b0;
          end else if (r_hold_cnt <= HOLD_W'(1)) begin
            r_contact <= 1'b0;
            r_phase   <= '0;
            r_tog     <= '0;
            if (HAS_BNC) begin
              r_state <= S_REL_BNC;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
          end
        end

        S_REL_BNC: begin
          if (abort) begin
            r_state   <= S_IDLE;
            r_contact <= 1'b0;
          end else if (w_phase_end) begin
            r_phase <= '0;
            if (w_tog_end) begin
              r_state   <= S_DONE;
              r_tog     <= '0;
              r_contact <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              // Next phase index is r_tog+1: closed when it is odd.
              r_tog     <= r_tog + TG_W'(1);
              r_contact <= ~r_tog[0];
            end
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end

        S_DONE: begin
          r_state   <= S_IDLE;
          r_contact <= 1'b0;
        end

        default: begin
          r_state   <= S_IDLE;
          r_contact <= 1'b0;
        end
      endcase
    end
  end

endmodule
